spi_sub: RTL
============

Name: spi_sub

Overview:
- SPI subordinate (responder) that sits at the far end of the link from the SPI main in the AES-over-SPI path.
- Receives bytes from the main on mosi and returns bytes on miso, full duplex, MSB first.
- Bus mode: CPOL=0, CPHA=1. Main drives mosi on the sclk rising edge and samples miso on the falling edge, so this block drives miso on the rising edge and samples mosi on the falling edge.
- The bus inputs are asynchronous to clk. They are oversampled and synchronized; every internal action runs on clk.

Parameters:
WIDTH, 8, bits per SPI word.
SYNC_STAGES, 2, flops in each synchronizer chain for sclk, cs_n and mosi (minimum 2).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
sclk  input  1  SPI clock from main; idles low.
cs_n  input  1  chip select from main, active-low.
mosi  input  1  serial data from main.
miso  output  1  serial data to main. Driven 0 while cs_n is high; no tristate.
tx_data  input  WIDTH  next word to send.
tx_load  input  1  one-cycle strobe that writes tx_data into the holding register.
tx_ready  output  1  high when the holding register is empty.
rx_data  output  WIDTH  last complete received word.
rx_valid  output  1  one-cycle pulse when rx_data updates.
busy  output  1  high while a frame is active.
frame_err  output  1  one-cycle pulse when a frame aborts mid-word.

Behaviour:
Clocking and reset:
- One clock: clk. Reset is asynchronous and active-low (rst_n).
- Reset values: miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, frame_err=0. The holding register, both shift registers and the bit counter clear. The synchronizer chains load the idle levels sclk=0, cs_n=1, mosi=0.

Synchronization and edge detection:
- sclk, cs_n and mosi each pass through SYNC_STAGES flops.
- Edge detection compares the last synchronized stage with one extra registered copy.
- Required bus timing: each sclk high and low phase is at least SYNC_STAGES+2 clk periods. Faster sclk is unsupported and unchecked.

State machine:
- IDLE:
  - busy=0, miso=0.
  - A synchronized cs_n falling edge moves to ACTIVE. On that transition the tx shift register loads the holding register (0 if the holding register is empty), the holding register empties (tx_ready=1), and the bit counter clears.
- ACTIVE:
  - busy=1.
  - Synchronized sclk rising edge: miso <= tx_shift[WIDTH-1], then tx_shift shifts left with 0 fill.
  - Synchronized sclk falling edge: rx_shift <= {rx_shift[WIDTH-2:0], synchronized mosi}, and the bit counter increments.
  - On the falling edge that completes bit WIDTH:
    - rx_data <= the completed word and rx_valid pulses in the next clk cycle.
    - The counter wraps to 0.
    - tx_shift reloads from the holding register (0 if empty) and the holding register empties. This gives back-to-back words with no gap while cs_n stays low.
  - Synchronized cs_n rising edge returns to IDLE. miso=0 from the next cycle.
    - If the bit counter is nonzero, frame_err pulses for one cycle and the partial word is discarded: no rx_valid, rx_data unchanged.
    - If the counter is 0, the frame ended cleanly.

Holding register:
- tx_load with tx_ready=1 latches tx_data and drops tx_ready the next cycle.
- tx_load with tx_ready=0 is ignored; the held data is unchanged.
- If tx_load coincides with a word-start consume in the same cycle, the consume takes the old contents (or 0 if empty), then the new tx_data is latched and tx_ready=0.

Simultaneous events and latency:
- A cs_n rising edge in the same synchronized cycle as an sclk edge: cs_n wins and the sclk edge is ignored.
- Latency from the last sclk falling edge at the pin to rx_valid is at most SYNC_STAGES+2 clk cycles.
- Latency from an sclk rising edge at the pin to the miso update is at most SYNC_STAGES+2 clk cycles.

Reset mid-frame: all state returns to reset values immediately. After rst_n deasserts, the block waits for a fresh cs_n falling edge; a low cs_n at reset release does not start a frame.

Test Plan:
- Single word: tx_load 8'h3C, main sends 8'hA5 (sclk = clk/10) -> main reads 8'h3C on miso; rx_data=8'hA5 with one rx_valid pulse; tx_ready=1 after cs_n falls; busy high for the frame only.
- Back-to-back: tx_load 8'h11, then reload 8'h22 after the first word; main sends 8'hF0, 8'h0F under one cs_n -> miso returns 8'h11 then 8'h22; two rx_valid pulses with rx_data 8'hF0 then 8'h0F.
- Underrun and ignored load: no tx_load before the frame -> miso returns 8'h00. Then tx_load 8'hAA followed by tx_load 8'h55 while tx_ready=0 -> the next frame returns 8'hAA.
- Abort: cs_n rises after 3 sclk cycles -> one frame_err pulse, no rx_valid, rx_data unchanged, miso=0, busy=0. The next full frame of 8'h5A is received correctly.
- Reset mid-frame: assert rst_n=0 after 4 bits -> all outputs at reset values immediately. With cs_n held low across reset release, no frame starts until cs_n toggles high then low.
- Timing edge: sclk phases at exactly SYNC_STAGES+2 clk periods, main sends 8'hC3 with 8'h81 loaded -> both words transfer correctly.

Source files
------------

// File: rtl/spi_sub_if.sv
// spi_sub_if: SPI bus pins plus the local tx/rx word handshake of the SPI subordinate.
interface spi_sub_if #(parameter int WIDTH = 8);
    logic             sclk;
    logic             cs_n;
    logic             mosi;
    logic             miso;
    logic [WIDTH-1:0] tx_data;
    logic             tx_load;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;
    logic             frame_err;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_load,
        output miso, tx_ready, rx_data, rx_valid, busy, frame_err
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_load,
        input  miso, tx_ready, rx_data, rx_valid, busy, frame_err
    );
endinterface

// File: rtl/spi_sub.sv
// spi_sub: CPOL=0/CPHA=1 SPI subordinate, oversampled on clk, full duplex MSB first
// with a one-word tx holding register and back-to-back words under one cs_n.
module spi_sub #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic       clk,
    input logic       rst_n,
    spi_sub_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_live;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic                   r_armed;
    logic [WIDTH-1:0]       r_hold;
    logic                   r_hold_full;
    logic [WIDTH-1:0]       r_tx_shift;
    logic [WIDTH-2:0]       r_rx_shift;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH-1:0]       r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_err;
    logic                   r_miso;

    logic             w_sclk;
    logic             w_cs;
    logic             w_mosi;
    logic             w_sclk_rise;
    logic             w_sclk_fall;
    logic             w_cs_fall;
    logic             w_cs_rise;
    logic             w_start;
    logic             w_stop;
    logic             w_rise;
    logic             w_fall;
    logic             w_last;
    logic             w_consume;
    logic [WIDTH-1:0] w_hold_out;
    logic [WIDTH-1:0] w_rx_next;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    // A frame may only start once cs_n has genuinely been seen high after reset.
    assign w_cs_fall   = r_armed & ~w_cs & r_cs_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;

    assign w_start    = (r_state == IDLE) & w_cs_fall;
    assign w_stop     = (r_state == ACTIVE) & w_cs_rise;
    assign w_rise     = (r_state == ACTIVE) & ~w_cs_rise & w_sclk_rise;
    assign w_fall     = (r_state == ACTIVE) & ~w_cs_rise & w_sclk_fall;
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_consume  = w_start | (w_fall & w_last);
    assign w_hold_out = r_hold_full ? r_hold : '0;
    assign w_rx_next  = {r_rx_shift, w_mosi};

    assign bus.miso      = r_miso;
    assign bus.tx_ready  = ~r_hold_full;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.busy      = (r_state == ACTIVE);
    assign bus.frame_err = r_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_live      <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            r_live      <= {r_live[SYNC_STAGES-2:0], 1'b1};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs;
            r_armed     <= r_armed | (r_live[SYNC_STAGES-1] & w_cs);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_start) w_next = ACTIVE;
        if (w_stop)  w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_cnt       <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_consume) r_hold_full <= 1'b0;
            // A load coinciding with a consume is accepted after the old word is taken.
            if (bus.tx_load && (!r_hold_full || w_consume)) begin
                r_hold      <= bus.tx_data;
                r_hold_full <= 1'b1;
            end
            if (w_start) begin
                r_tx_shift <= w_hold_out;
                r_cnt      <= '0;
            end else if (w_stop) begin
                r_miso      <= 1'b0;
                r_cnt       <= '0;
                r_frame_err <= (r_cnt != '0);
            end else if (w_rise) begin
                r_miso     <= r_tx_shift[WIDTH-1];
                r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
            end else if (w_fall) begin
                r_rx_shift <= w_rx_next[WIDTH-2:0];
                r_cnt      <= w_last ? '0 : CW'(r_cnt + 1'b1);
                if (w_last) begin
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                    r_tx_shift <= w_hold_out;
                end
            end
        end
    end
endmodule
